// File: rtl/servo_route_sequencer.sv
// Route player for the two-wheel servo car: steps through a table of {dir, duration}
// segments and drives left/right continuous-servo PWM with period-aligned width updates.
//
// state | meaning
// IDLE  | waiting for start; segment table writable
// LOAD  | one cycle: fetch entry[seg_idx], arm duration counter and prescaler
// RUN   | direction applied, counting duration ticks down to the segment end
module servo_route_sequencer #(
  parameter int NUM_SEG   = 8,
  parameter int DUR_W     = 11,
  parameter int TICK_DIV  = 1000,
  parameter int PERIOD    = 2000,
  parameter int PULSE_POS = 150,
  parameter int PULSE_NEG = 157,
  localparam int AW = $clog2(NUM_SEG)
) (
  input  logic             clk_26,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [1:0]       wr_dir,
  input  logic [DUR_W-1:0] wr_dur,
  input  logic             start,
  input  logic [AW:0]      seg_count,
  input  logic             loop_en,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    cur_seg,
  output logic [1:0]       dir,
  output logic             signal_left,
  output logic             signal_right
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] PWM_MAX   = CW'(PERIOD - 1);
  localparam logic [CW-1:0] POS_W     = CW'(PULSE_POS);
  localparam logic [CW-1:0] NEG_W     = CW'(PULSE_NEG);
  localparam logic [AW:0]   NSEG_MAX  = (AW+1)'(NUM_SEG);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    seg_idx_q, seg_idx_d;
  logic [AW:0]      n_q, n_d;
  logic             loop_q, loop_d;
  logic [DUR_W-1:0] dur_cnt_q, dur_cnt_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [1:0]       dir_q, dir_d;
  logic             done_q, done_d;

  logic [CW-1:0]    pwm_cnt_q, pwm_cnt_d;
  logic [CW-1:0]    width_l_q, width_l_d;
  logic [CW-1:0]    width_r_q, width_r_d;
  logic             sig_l_q, sig_l_d;
  logic             sig_r_q, sig_r_d;

  logic [1:0]       tbl_dir_q [NUM_SEG];
  logic [1:0]       tbl_dir_d [NUM_SEG];
  logic [DUR_W-1:0] tbl_dur_q [NUM_SEG];
  logic [DUR_W-1:0] tbl_dur_d [NUM_SEG];

  logic [1:0]       cur_dir;
  logic [DUR_W-1:0] cur_dur;
  logic             last_seg;
  logic             advance;

  assign cur_dir  = tbl_dir_q[seg_idx_q];
  assign cur_dur  = tbl_dur_q[seg_idx_q];
  assign last_seg = ({1'b0, seg_idx_q} == (n_q - (AW+1)'(1)));

  // Table is only writable while idle so a running route never sees a torn entry.
  always_comb begin
    tbl_dir_d = tbl_dir_q;
    tbl_dur_d = tbl_dur_q;
    if (wr_en && (state_q == ST_IDLE)) begin
      tbl_dir_d[wr_addr] = wr_dir;
      tbl_dur_d[wr_addr] = wr_dur;
    end
  end

  always_ff @(posedge clk_26) begin
    tbl_dir_q <= tbl_dir_d;
    tbl_dur_q <= tbl_dur_d;
  end

  always_comb begin
    state_d   = state_q;
    seg_idx_d = seg_idx_q;
    n_d       = n_q;
    loop_d    = loop_q;
    dur_cnt_d = dur_cnt_q;
    presc_d   = presc_q;
    dir_d     = dir_q;
    done_d    = 1'b0;
    advance   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (seg_count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d   = ST_LOAD;
            seg_idx_d = '0;
            n_d       = (seg_count > NSEG_MAX) ? NSEG_MAX : seg_count;
            loop_d    = loop_en;
          end
        end
      end
      ST_LOAD: begin
        dur_cnt_d = cur_dur;
        presc_d   = '0;
        if (cur_dur == '0) begin
          advance = 1'b1;
        end else begin
          state_d = ST_RUN;
          dir_d   = cur_dir;
        end
      end
      ST_RUN: begin
        if (presc_q == PRESC_MAX) begin
          presc_d = '0;
          if (dur_cnt_q == DUR_W'(1)) begin
            advance = 1'b1;
          end else begin
            dur_cnt_d = dur_cnt_q - DUR_W'(1);
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (advance) begin
      if (!last_seg) begin
        seg_idx_d = seg_idx_q + AW'(1);
        state_d   = ST_LOAD;
      end else if (loop_q) begin
        seg_idx_d = '0;
        state_d   = ST_LOAD;
      end else begin
        state_d = ST_IDLE;
        dir_d   = 2'b00;
        done_d  = 1'b1;
      end
    end

    // Abort wins over everything, including a start in the same cycle.
    if (abort) begin
      state_d = ST_IDLE;
      dir_d   = 2'b00;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_26) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      seg_idx_q <= '0;
      n_q       <= '0;
      loop_q    <= 1'b0;
      dur_cnt_q <= '0;
      presc_q   <= '0;
      dir_q     <= 2'b00;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      seg_idx_q <= seg_idx_d;
      n_q       <= n_d;
      loop_q    <= loop_d;
      dur_cnt_q <= dur_cnt_d;
      presc_q   <= presc_d;
      dir_q     <= dir_d;
      done_q    <= done_d;
    end
  end

  // Widths are sampled only at period start, so a mid-period dir change never truncates a pulse.
  always_comb begin
    pwm_cnt_d = (pwm_cnt_q == PWM_MAX) ? '0 : pwm_cnt_q + CW'(1);
    width_l_d = width_l_q;
    width_r_d = width_r_q;
    if (pwm_cnt_q == '0) begin
      case (dir_q)
        2'b01: begin
          width_l_d = NEG_W;
          width_r_d = POS_W;
        end
        2'b10: begin
          width_l_d = POS_W;
          width_r_d = NEG_W;
        end
        2'b11: begin
          width_l_d = POS_W;
          width_r_d = POS_W;
        end
        default: begin
          width_l_d = '0;
          width_r_d = '0;
        end
      endcase
    end
    sig_l_d = (pwm_cnt_q < width_l_d);
    sig_r_d = (pwm_cnt_q < width_r_d);
  end

  always_ff @(posedge clk_26) begin
    if (rst) begin
      pwm_cnt_q <= '0;
      width_l_q <= '0;
      width_r_q <= '0;
      sig_l_q   <= 1'b0;
      sig_r_q   <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      width_l_q <= width_l_d;
      width_r_q <= width_r_d;
      sig_l_q   <= sig_l_d;
      sig_r_q   <= sig_r_d;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;
  assign cur_seg      = busy ? seg_idx_q : '0;
  assign dir          = dir_q;
  assign signal_left  = sig_l_q;
  assign signal_right = sig_r_q;

endmodule

// File: tb/tb_servo_route_sequencer.sv
// Bench for servo_route_sequencer: routes are expanded into an expected per-cycle trace
// from the segment table, and PWM is predicted per period from that trace.
module tb_servo_route_sequencer;

  localparam int NUM_SEG   = 4;
  localparam int DUR_W     = 11;
  localparam int TICK_DIV  = 2;
  localparam int PERIOD    = 20;
  localparam int PULSE_POS = 3;
  localparam int PULSE_NEG = 5;
  localparam int AW        = 2;

  logic             clk_26 = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [1:0]       wr_dir;
  logic [DUR_W-1:0] wr_dur;
  logic             start;
  logic [AW:0]      seg_count;
  logic             loop_en;
  logic             abort;
  logic             busy;
  logic             done;
  logic [AW-1:0]    cur_seg;
  logic [1:0]       dir;
  logic             signal_left;
  logic             signal_right;

  servo_route_sequencer #(
    .NUM_SEG(NUM_SEG), .DUR_W(DUR_W), .TICK_DIV(TICK_DIV),
    .PERIOD(PERIOD), .PULSE_POS(PULSE_POS), .PULSE_NEG(PULSE_NEG)
  ) dut (
    .clk_26(clk_26), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_dir(wr_dir),
    .wr_dur(wr_dur), .start(start), .seg_count(seg_count), .loop_en(loop_en),
    .abort(abort), .busy(busy), .done(done), .cur_seg(cur_seg), .dir(dir),
    .signal_left(signal_left), .signal_right(signal_right)
  );

  always #5 clk_26 = ~clk_26;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic [1:0]    dir;
    logic [AW-1:0] cur;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t obs;
  logic [1:0] m_dir [NUM_SEG];
  int         m_dur [NUM_SEG];

  function automatic exp_t mk(input logic b, input logic d, input logic [1:0] dr, input int c);
    exp_t r;
    r.busy = b;
    r.done = d;
    r.dir  = dr;
    r.cur  = AW'(c);
    return r;
  endfunction

  function automatic int want_left(input logic [1:0] d);
    case (d)
      2'b01:   return PULSE_NEG;
      2'b10:   return PULSE_POS;
      2'b11:   return PULSE_POS;
      default: return 0;
    endcase
  endfunction

  function automatic int want_right(input logic [1:0] d);
    case (d)
      2'b01:   return PULSE_POS;
      2'b10:   return PULSE_NEG;
      2'b11:   return PULSE_POS;
      default: return 0;
    endcase
  endfunction

  // Expected outputs after each edge following the start edge.
  task automatic build_trace(input int n_raw, input bit lp, input int max_len);
    int n;
    logic [1:0] prev;
    exp_q.delete();
    n = (n_raw > NUM_SEG) ? NUM_SEG : n_raw;
    if (n == 0) begin
      exp_q.push_back(mk(1'b0, 1'b1, 2'b00, 0));
      return;
    end
    prev = 2'b00;
    do begin
      for (int i = 0; i < n && exp_q.size() < max_len; i++) begin
        exp_q.push_back(mk(1'b1, 1'b0, prev, i));
        for (int c = 0; c < m_dur[i] * TICK_DIV && exp_q.size() < max_len; c++)
          exp_q.push_back(mk(1'b1, 1'b0, m_dir[i], i));
        if (m_dur[i] > 0) prev = m_dir[i];
      end
    end while (lp && exp_q.size() < max_len);
    if (!lp) exp_q.push_back(mk(1'b0, 1'b1, 2'b00, 0));
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = '0; wr_dir = 2'b00; wr_dur = '0;
    start = 1'b0; seg_count = '0; loop_en = 1'b0; abort = 1'b0;
  endtask

  task automatic write_seg(input int a, input int d, input int dur);
    wr_en = 1'b1; wr_addr = AW'(a); wr_dir = 2'(d); wr_dur = DUR_W'(dur);
    @(negedge clk_26);
    wr_en = 1'b0;
    m_dir[a] = 2'(d);
    m_dur[a] = dur;
  endtask

  task automatic launch(input int n, input bit lp);
    start = 1'b1; seg_count = (AW+1)'(n); loop_en = lp;
    @(negedge clk_26);
    start = 1'b0; loop_en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk_26);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (cur_seg !== '0) begin errors++; $display("FAIL reset_cur got=%0d want=0", cur_seg); end
    checks++; if (dir !== 2'b00) begin errors++; $display("FAIL reset_dir got=%b want=00", dir); end
    checks++; if (signal_left !== 1'b0) begin errors++; $display("FAIL reset_sl got=%b want=0", signal_left); end
    checks++; if (signal_right !== 1'b0) begin errors++; $display("FAIL reset_sr got=%b want=0", signal_right); end
    rst = 1'b0;
    @(negedge clk_26);
    obs = exp_t'({busy, done, dir, cur_seg});
    checks++; if (obs !== mk(1'b0, 1'b0, 2'b00, 0)) begin errors++; $display("FAIL post_reset got=%h want=%h", obs, mk(1'b0, 1'b0, 2'b00, 0)); end
  endtask

  task automatic test_basic_route();
    int nb = 0;
    write_seg(0, 1, 3);
    write_seg(1, 2, 2);
    build_trace(2, 1'b0, 1000);
    launch(2, 1'b0);
    for (int k = 0; k < exp_q.size(); k++) begin
      obs = exp_t'({busy, done, dir, cur_seg});
      if (obs.busy) nb++;
      checks++;
      if (obs !== exp_q[k]) begin errors++; $display("FAIL basic k=%0d got=%h want=%h", k, obs, exp_q[k]); end
      @(negedge clk_26);
    end
    checks++; if (nb != 12) begin errors++; $display("FAIL basic_busy_len got=%0d want=12", nb); end
    obs = exp_t'({busy, done, dir, cur_seg});
    checks++; if (obs !== mk(1'b0, 1'b0, 2'b00, 0)) begin errors++; $display("FAIL basic_idle got=%h want=%h", obs, mk(1'b0, 1'b0, 2'b00, 0)); end
  endtask

  task automatic test_zero_dur();
    int nb = 0;
    int n01 = 0;
    write_seg(0, 1, 0);
    write_seg(1, 2, 1);
    build_trace(2, 1'b0, 1000);
    launch(2, 1'b0);
    for (int k = 0; k < exp_q.size(); k++) begin
      obs = exp_t'({busy, done, dir, cur_seg});
      if (obs.busy) nb++;
      if (obs.dir == 2'b01) n01++;
      checks++;
      if (obs !== exp_q[k]) begin errors++; $display("FAIL zero_dur k=%0d got=%h want=%h", k, obs, exp_q[k]); end
      @(negedge clk_26);
    end
    checks++; if (nb != 4) begin errors++; $display("FAIL zero_dur_busy_len got=%0d want=4", nb); end
    checks++; if (n01 != 0) begin errors++; $display("FAIL zero_dur_dir01 got=%0d want=0", n01); end
  endtask

  task automatic test_loop_abort();
    write_seg(0, 1, 1);
    write_seg(1, 3, 2);
    build_trace(2, 1'b1, 14);
    launch(2, 1'b1);
    for (int k = 0; k < exp_q.size(); k++) begin
      obs = exp_t'({busy, done, dir, cur_seg});
      checks++;
      if (obs !== exp_q[k]) begin errors++; $display("FAIL loop k=%0d got=%h want=%h", k, obs, exp_q[k]); end
      @(negedge clk_26);
    end
    abort = 1'b1;
    @(negedge clk_26);
    abort = 1'b0;
    obs = exp_t'({busy, done, dir, cur_seg});
    checks++; if (obs !== mk(1'b0, 1'b0, 2'b00, 0)) begin errors++; $display("FAIL abort_run got=%h want=%h", obs, mk(1'b0, 1'b0, 2'b00, 0)); end
    start = 1'b1; abort = 1'b1; seg_count = 3'd2;
    @(negedge clk_26);
    start = 1'b0; abort = 1'b0;
    for (int k = 0; k < 2; k++) begin
      obs = exp_t'({busy, done, dir, cur_seg});
      checks++;
      if (obs !== mk(1'b0, 1'b0, 2'b00, 0)) begin errors++; $display("FAIL abort_start k=%0d got=%h want=%h", k, obs, mk(1'b0, 1'b0, 2'b00, 0)); end
      @(negedge clk_26);
    end
  endtask

  task automatic test_clamp_protect();
    build_trace(0, 1'b0, 1000);
    launch(0, 1'b0);
    for (int k = 0; k < exp_q.size() + 2; k++) begin
      obs = exp_t'({busy, done, dir, cur_seg});
      checks++;
      if (obs !== ((k < exp_q.size()) ? exp_q[k] : mk(1'b0, 1'b0, 2'b00, 0))) begin
        errors++; $display("FAIL n_zero k=%0d got=%h", k, obs);
      end
      @(negedge clk_26);
    end
    write_seg(1, 0, 1);
    write_seg(2, 2, 0);
    write_seg(3, 1, 2);
    // Write of seg0 in the same cycle as start must be seen by the first LOAD.
    wr_en = 1'b1; wr_addr = 2'd0; wr_dir = 2'b11; wr_dur = DUR_W'(2);
    m_dir[0] = 2'b11; m_dur[0] = 2;
    for (int pass = 0; pass < 2; pass++) begin
      build_trace((pass == 0) ? 7 : 4, 1'b0, 1000);
      launch((pass == 0) ? 7 : 4, 1'b0);
      for (int k = 0; k < exp_q.size(); k++) begin
        obs = exp_t'({busy, done, dir, cur_seg});
        checks++;
        if (obs !== exp_q[k]) begin errors++; $display("FAIL clamp pass=%0d k=%0d got=%h want=%h", pass, k, obs, exp_q[k]); end
        if (exp_q[k].busy) begin
          wr_en = 1'b1; wr_addr = AW'($urandom_range(0, NUM_SEG - 1));
          wr_dir = 2'($urandom_range(0, 3)); wr_dur = DUR_W'($urandom_range(3, 6));
        end else begin
          wr_en = 1'b0;
        end
        @(negedge clk_26);
      end
      wr_en = 1'b0;
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int n;
      for (int a = 0; a < NUM_SEG; a++) write_seg(a, $urandom_range(0, 3), $urandom_range(0, 3));
      n = $urandom_range(0, 7);
      build_trace(n, 1'b0, 1000);
      launch(n, 1'b0);
      for (int k = 0; k < exp_q.size() + 1; k++) begin
        obs = exp_t'({busy, done, dir, cur_seg});
        checks++;
        if (obs !== ((k < exp_q.size()) ? exp_q[k] : mk(1'b0, 1'b0, 2'b00, 0))) begin
          errors++; $display("FAIL random it=%0d n=%0d k=%0d got=%h", it, n, k, obs);
        end
        if (k < exp_q.size() && exp_q[k].busy && ($urandom_range(0, 1) == 1)) begin
          wr_en = 1'b1; wr_addr = AW'($urandom_range(0, NUM_SEG - 1));
          wr_dir = 2'($urandom_range(0, 3)); wr_dur = DUR_W'($urandom_range(0, 7));
        end else begin
          wr_en = 1'b0;
        end
        @(negedge clk_26);
      end
      wr_en = 1'b0;
    end
  endtask

  // PWM phase is known from reset release: edge e (first edge with rst low is e=0) sees
  // counter value e%PERIOD, and each period uses the dir present just before its first edge.
  task automatic test_pwm();
    logic [1:0] da [140];
    int hl, hr, p, want_hl, want_hr;
    logic [1:0] pd;
    logic el, er;
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk_26);
    rst = 1'b0;
    write_seg(0, 1, 20);
    write_seg(1, 2, 15);
    repeat (6) @(negedge clk_26);
    build_trace(2, 1'b0, 1000);
    for (int i = 0; i < 140; i++) da[i] = 2'b00;
    for (int k = 0; k < exp_q.size(); k++) da[8 + k] = exp_q[k].dir;
    launch(2, 1'b0);
    hl = 0; hr = 0;
    for (int e = 8; e < 120; e++) begin
      p  = e / PERIOD;
      pd = (p == 0) ? 2'b00 : da[p * PERIOD - 1];
      el = ((e % PERIOD) < want_left(pd));
      er = ((e % PERIOD) < want_right(pd));
      checks++; if (dir !== da[e]) begin errors++; $display("FAIL pwm_dir e=%0d got=%b want=%b", e, dir, da[e]); end
      checks++; if (signal_left !== el) begin errors++; $display("FAIL pwm_left e=%0d got=%b want=%b", e, signal_left, el); end
      checks++; if (signal_right !== er) begin errors++; $display("FAIL pwm_right e=%0d got=%b want=%b", e, signal_right, er); end
      if (e >= PERIOD) begin
        hl += int'(signal_left);
        hr += int'(signal_right);
      end
      if (e >= PERIOD && e < 4 * PERIOD && (e % PERIOD) == PERIOD - 1) begin
        want_hl = (p == 3) ? PULSE_POS : PULSE_NEG;
        want_hr = (p == 3) ? PULSE_NEG : PULSE_POS;
        checks++; if (hl != want_hl) begin errors++; $display("FAIL pwm_left_count p=%0d got=%0d want=%0d", p, hl, want_hl); end
        checks++; if (hr != want_hr) begin errors++; $display("FAIL pwm_right_count p=%0d got=%0d want=%0d", p, hr, want_hr); end
      end
      if ((e % PERIOD) == PERIOD - 1) begin
        hl = 0; hr = 0;
      end
      @(negedge clk_26);
    end
  endtask

  initial begin
    test_reset();
    test_basic_route();
    test_zero_dur();
    test_loop_abort();
    test_clamp_protect();
    test_random();
    test_pwm();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
